mem_lsu: RTL

- Memory-stage load/store unit of the 5-stage CPU pipeline.
- Takes the executed instruction from the EX/MEM boundary and runs the data-memory bus handshake for loads and stores.
- Produces the write-back triple (mem_wdata, mem_wd, mem_wreg) that feeds the MEM/WB pipeline register.
- Asserts stallreq to the pipeline controller while a memory access is outstanding.

---
 rtl/mem_lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 85 ++++++++
 rtl/mem_lsu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared encodings and widths for the memory-stage load/store unit
package mem_lsu_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 5;
   localparam int MEM_ADDR_W = 32;

   localparam logic [REG_DATA_W-1:0] ZERO_WORD     = '0;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;
   localparam logic                  WRITE_ENABLE  = 1'b1;
   localparam logic                  WRITE_DISABLE = 1'b0;

   typedef enum logic [3:0] {
      MEMOP_NONE = 4'd0,
      MEMOP_LB   = 4'd1,
      MEMOP_LBU  = 4'd2,
      MEMOP_LH   = 4'd3,
      MEMOP_LHU  = 4'd4,
      MEMOP_LW   = 4'd5,
      MEMOP_SB   = 4'd6,
      MEMOP_SH   = 4'd7,
      MEMOP_SW   = 4'd8
   } memop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   function automatic logic memop_is_load(input logic [3:0] op);
      return (op >= MEMOP_LB) && (op <= MEMOP_LW);
   endfunction

   function automatic logic memop_is_store(input logic [3:0] op);
      return (op >= MEMOP_SB) && (op <= MEMOP_SW);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane select, store replication and load extract/extend (MEM_LSU_MISALIGN_EXC_EN)
import mem_lsu_pkg::*;

module lsu_align (
   input  logic [3:0]  memop_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o,
   output logic        misaligned_o
);

   logic [1:0]  off;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Effective lane offset: halfword/word ops drop the low address bits; with the
   // exception build those bits instead flag a misaligned access.
   always_comb begin
      off          = addr_lo_i;
      misaligned_o = 1'b0;
      case (memop_i)
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
`ifdef MEM_LSU_MISALIGN_EXC_EN
            misaligned_o = addr_lo_i[0];
`endif
            off = {addr_lo_i[1], 1'b0};
         end
         MEMOP_LW, MEMOP_SW: begin
`ifdef MEM_LSU_MISALIGN_EXC_EN
            misaligned_o = |addr_lo_i;
`endif
            off = 2'b00;
         end
         default: off = addr_lo_i;
      endcase
   end

   // Lane enables, replicated store data and extended load data per op.
   always_comb begin
      byte_v  = rdata_i[{off, 3'b000} +: 8];
      half_v  = rdata_i[{off[1], 4'b0000} +: 16];
      sel_o   = 4'b0000;
      wdata_o = '0;
      ldata_o = '0;
      case (memop_i)
         MEMOP_LB: begin
            sel_o   = 4'b0001 << off;
            ldata_o = {{24{byte_v[7]}}, byte_v};
         end
         MEMOP_LBU: begin
            sel_o   = 4'b0001 << off;
            ldata_o = {24'h000000, byte_v};
         end
         MEMOP_LH: begin
            sel_o   = off[1] ? 4'b1100 : 4'b0011;
            ldata_o = {{16{half_v[15]}}, half_v};
         end
         MEMOP_LHU: begin
            sel_o   = off[1] ? 4'b1100 : 4'b0011;
            ldata_o = {16'h0000, half_v};
         end
         MEMOP_LW: begin
            sel_o   = 4'b1111;
            ldata_o = rdata_i;
         end
         MEMOP_SB: begin
            sel_o   = 4'b0001 << off;
            wdata_o = {4{sdata_i[7:0]}};
         end
         MEMOP_SH: begin
            sel_o   = off[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{sdata_i[15:0]}};
         end
         MEMOP_SW: begin
            sel_o   = 4'b1111;
            wdata_o = sdata_i;
         end
         default: sel_o = 4'b0000;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-stage load/store unit with bus handshake and stall (MEM_LSU_MISALIGN_EXC_EN)
import mem_lsu_pkg::*;

module mem_lsu #(
   parameter int DW  = REG_DATA_W,
   parameter int AW  = REG_ADDR_W,
   parameter int MAW = MEM_ADDR_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [AW-1:0]  ex_wd,
   input  logic           ex_wreg,
   input  logic [DW-1:0]  ex_wdata,
   input  logic [3:0]     ex_memop,
   input  logic [MAW-1:0] ex_addr,
   input  logic [DW-1:0]  ex_sdata,
   output logic           dm_req,
   output logic           dm_we,
   output logic [MAW-1:0] dm_addr,
   output logic [3:0]     dm_sel,
   output logic [DW-1:0]  dm_wdata,
   input  logic           dm_gnt,
   input  logic           dm_rvalid,
   input  logic [DW-1:0]  dm_rdata,
   output logic [DW-1:0]  mem_wdata,
   output logic [AW-1:0]  mem_wd,
   output logic           mem_wreg,
   output logic           stallreq,
   output logic           misalign
);

   lsu_state_e    state_q, state_d;
   logic [DW-1:0] result_q, result_d;

   logic          is_ld, is_st, is_mem;
   logic [3:0]    sel_w;
   logic [31:0]   wdata_w, ldata_w;
   logic          mis_w;

   assign is_ld  = memop_is_load(ex_memop);
   assign is_st  = memop_is_store(ex_memop);
   assign is_mem = is_ld | is_st;

   lsu_align u_align (
      .memop_i      (ex_memop),
      .addr_lo_i    (ex_addr[1:0]),
      .sdata_i      (ex_sdata),
      .rdata_i      (dm_rdata),
      .sel_o        (sel_w),
      .wdata_o      (wdata_w),
      .ldata_o      (ldata_w),
      .misaligned_o (mis_w)
   );

   // Capture the extended load data only while waiting for the response, so a
   // response coincident with the grant or arriving in IDLE is never taken.
   always_comb begin
      result_d = result_q;
      if (state_q == ST_WAIT && dm_rvalid) begin
         result_d = ldata_w;
      end
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= ZERO_WORD;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   // Next state and all outputs; reset forces every output low in the same cycle.
   always_comb begin
      state_d   = state_q;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_sel    = 4'b0000;
      dm_wdata  = '0;
      mem_wdata = ZERO_WORD;
      mem_wd    = ZERO_REG_ADDR;
      mem_wreg  = WRITE_DISABLE;
      stallreq  = 1'b0;
      misalign  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!is_mem) begin
               mem_wdata = ex_wdata;
               mem_wd    = ex_wd;
               mem_wreg  = ex_wreg;
            end else if (mis_w) begin
               misalign = 1'b1;
               mem_wd   = ex_wd;
            end else begin
               dm_req   = 1'b1;
               dm_we    = is_st;
               dm_addr  = {ex_addr[MAW-1:2], 2'b00};
               dm_sel   = sel_w;
               dm_wdata = wdata_w;
               stallreq = 1'b1;
               if (dm_gnt) begin
                  state_d = is_st ? ST_DONE : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            stallreq = 1'b1;
            if (dm_rvalid) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            mem_wd = ex_wd;
            if (is_ld) begin
               mem_wreg  = ex_wreg;
               mem_wdata = result_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rst) begin
         state_d   = ST_IDLE;
         dm_req    = 1'b0;
         dm_we     = 1'b0;
         dm_addr   = '0;
         dm_sel    = 4'b0000;
         dm_wdata  = '0;
         mem_wdata = ZERO_WORD;
         mem_wd    = ZERO_REG_ADDR;
         mem_wreg  = WRITE_DISABLE;
         stallreq  = 1'b0;
         misalign  = 1'b0;
      end
   end

endmodule
